// File: rtl/bc_pkg.sv
// Shared types and constants for the turn sequencer: phase encoding, digit count, win threshold.
// Also provides the guess-validity check used when a player confirms an entry.
package bc_pkg;

    typedef enum logic [2:0] {
        SETUP_J1 = 3'd0,
        SETUP_J2 = 3'd1,
        GUESS    = 3'd2,
        SCORE    = 3'd3,
        WIN      = 3'd4
    } phase_t;

    localparam int DIGITS    = 4;
    localparam int BULLS_WIN = 4;

    // An entry is usable when every digit is decimal and no digit repeats.
    function automatic logic valid_entry(input logic [4*DIGITS-1:0] g);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (g[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < DIGITS; j++) begin
                if (g[4*i +: 4] == g[4*j +: 4]) ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/turn_sequencer_btn_edge.sv
// Push-button synchroniser and rising-edge detector; tick is a 1-cycle pulse 3 clocks after in rises.
// A button already held when reset releases produces no tick; no backpressure.
module btn_edge (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic tick
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [1:0] fill;

    // prev stays high until sync2 carries a real sample, so a held button reads as "already pressed".
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b1;
            fill  <= 2'b00;
            tick  <= 1'b0;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
            fill  <= {fill[0], 1'b1};
            prev  <= fill[1] ? sync2 : 1'b1;
            tick  <= sync2 & ~prev;
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Two-player bulls-and-cows turn controller: secret setup, guess hand-off to an external scorer, win tally.
// score_req is held until score_ack is sampled; confirm ticks arriving during scoring are dropped.
module turn_sequencer
    import bc_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [15:0]      guess,
    input  logic             confirm,
    output logic             score_req,
    output logic [15:0]      score_guess,
    output logic [15:0]      score_secret,
    input  logic             score_ack,
    input  logic [2:0]       bulls,
    input  logic [2:0]       cows,
    output logic [2:0]       phase,
    output logic             player,
    output logic [CNT_W-1:0] attempts,
    output logic [CNT_W-1:0] wins_j1,
    output logic [CNT_W-1:0] wins_j2,
    output logic [2:0]       last_bulls,
    output logic [2:0]       last_cows,
    output logic             err
);

    phase_t           state;
    logic             tick;
    logic             entry_ok;
    logic [15:0]      secret_j1;
    logic [15:0]      secret_j2;
    logic [CNT_W-1:0] att_j1;
    logic [CNT_W-1:0] att_j2;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    btn_edge u_btn_edge (
        .clock (clock),
        .reset (reset),
        .in    (confirm),
        .tick  (tick)
    );

    assign entry_ok = valid_entry(guess);
    assign phase    = state;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= SETUP_J1;
            score_req    <= 1'b0;
            score_guess  <= '0;
            score_secret <= '0;
            secret_j1    <= '0;
            secret_j2    <= '0;
            att_j1       <= '0;
            att_j2       <= '0;
            attempts     <= '0;
            wins_j1      <= '0;
            wins_j2      <= '0;
            last_bulls   <= '0;
            last_cows    <= '0;
            player       <= 1'b0;
            err          <= 1'b0;
        end else begin
            case (state)
                SETUP_J1: begin
                    if (tick) begin
                        err <= ~entry_ok;
                        if (entry_ok) begin
                            secret_j1 <= guess;
                            state     <= SETUP_J2;
                        end
                    end
                end
                SETUP_J2: begin
                    if (tick) begin
                        err <= ~entry_ok;
                        if (entry_ok) begin
                            secret_j2 <= guess;
                            player    <= 1'b0;
                            attempts  <= att_j1;
                            state     <= GUESS;
                        end
                    end
                end
                GUESS: begin
                    if (tick) begin
                        err <= ~entry_ok;
                        if (entry_ok) begin
                            score_guess <= guess;
                            score_req   <= 1'b1;
                            if (!player) begin
                                score_secret <= secret_j2;
                                att_j1       <= sat_inc(att_j1);
                                attempts     <= sat_inc(att_j1);
                            end else begin
                                score_secret <= secret_j1;
                                att_j2       <= sat_inc(att_j2);
                                attempts     <= sat_inc(att_j2);
                            end
                            state <= SCORE;
                        end
                    end
                end
                SCORE: begin
                    if (score_ack) begin
                        score_req  <= 1'b0;
                        last_bulls <= bulls;
                        last_cows  <= cows;
                        if (bulls == 3'(BULLS_WIN)) begin
                            if (!player) wins_j1 <= sat_inc(wins_j1);
                            else         wins_j2 <= sat_inc(wins_j2);
                            state <= WIN;
                        end else begin
                            // attempts follows the player who takes the next turn
                            player   <= ~player;
                            attempts <= player ? att_j1 : att_j2;
                            state    <= GUESS;
                        end
                    end
                end
                WIN: begin
                    if (tick) begin
                        att_j1     <= '0;
                        att_j2     <= '0;
                        attempts   <= '0;
                        secret_j1  <= '0;
                        secret_j2  <= '0;
                        last_bulls <= '0;
                        last_cows  <= '0;
                        player     <= 1'b0;
                        state      <= SETUP_J1;
                    end
                end
                default: state <= SETUP_J1;
            endcase
        end
    end

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: setup, entry rejection, scoring handshake, win, saturation, reset cases.
module tb_turn_sequencer;
    import bc_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] guess;
    logic        confirm;
    logic        score_req;
    logic [15:0] score_guess;
    logic [15:0] score_secret;
    logic        score_ack;
    logic [2:0]  bulls;
    logic [2:0]  cows;
    logic [2:0]  phase;
    logic        player;
    logic [3:0]  attempts;
    logic [3:0]  wins_j1;
    logic [3:0]  wins_j2;
    logic [2:0]  last_bulls;
    logic [2:0]  last_cows;
    logic        err;

    int checks = 0;
    int passes = 0;

    always #5 clock = ~clock;

    turn_sequencer #(.CNT_W(4)) dut (
        .clock        (clock),
        .reset        (reset),
        .guess        (guess),
        .confirm      (confirm),
        .score_req    (score_req),
        .score_guess  (score_guess),
        .score_secret (score_secret),
        .score_ack    (score_ack),
        .bulls        (bulls),
        .cows         (cows),
        .phase        (phase),
        .player       (player),
        .attempts     (attempts),
        .wins_j1      (wins_j1),
        .wins_j2      (wins_j2),
        .last_bulls   (last_bulls),
        .last_cows    (last_cows),
        .err          (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic press(input logic [15:0] v);
        @(negedge clock);
        guess   = v;
        confirm = 1'b1;
        repeat (6) @(negedge clock);
        confirm = 1'b0;
        repeat (4) @(negedge clock);
    endtask

    task automatic ack(input logic [2:0] b, input logic [2:0] c);
        @(negedge clock);
        score_ack = 1'b1;
        bulls     = b;
        cows      = c;
        @(negedge clock);
        score_ack = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        confirm   = 1'b0;
        guess     = 16'h0000;
        score_ack = 1'b0;
        bulls     = 3'd0;
        cows      = 3'd0;
        #12;
        check("rst_phase", 32'(phase), 32'(SETUP_J1));
        check("rst_req", 32'(score_req), 0);
        check("rst_err", 32'(err), 0);
        check("rst_player", 32'(player), 0);
        check("rst_attempts", 32'(attempts), 0);
        check("rst_wins_j2", 32'(wins_j2), 0);
        check("rst_score_secret", 32'(score_secret), 0);
        @(negedge clock);
        reset = 1'b0;

        // Secret setup
        press(16'h1234);
        check("setup1_phase", 32'(phase), 32'(SETUP_J2));
        press(16'h5678);
        check("setup2_phase", 32'(phase), 32'(GUESS));
        check("setup2_player", 32'(player), 0);
        check("setup2_attempts", 32'(attempts), 0);
        check("setup2_err", 32'(err), 0);

        // J1 guess with delayed ack
        press(16'h5670);
        check("g1_req", 32'(score_req), 1);
        check("g1_secret", 32'(score_secret), 32'h5678);
        check("g1_guess", 32'(score_guess), 32'h5670);
        check("g1_phase", 32'(phase), 32'(SCORE));
        check("g1_attempts", 32'(attempts), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("g1_req_hold", 32'(score_req), 1);
        end
        ack(3'd3, 3'd0);
        check("g1_last_bulls", 32'(last_bulls), 3);
        check("g1_player", 32'(player), 1);
        check("g1_attempts_j2", 32'(attempts), 0);
        check("g1_phase_after", 32'(phase), 32'(GUESS));
        check("g1_req_drop", 32'(score_req), 0);

        // Ack while idle is ignored
        ack(3'd4, 3'd0);
        check("stale_phase", 32'(phase), 32'(GUESS));
        check("stale_last_bulls", 32'(last_bulls), 3);
        check("stale_wins_j2", 32'(wins_j2), 0);

        // Invalid guess in GUESS
        press(16'h9999);
        check("inv_guess_err", 32'(err), 1);
        check("inv_guess_phase", 32'(phase), 32'(GUESS));
        check("inv_guess_attempts", 32'(attempts), 0);

        // J2 wins
        press(16'h1234);
        check("g2_err", 32'(err), 0);
        check("g2_secret", 32'(score_secret), 32'h1234);
        check("g2_attempts", 32'(attempts), 1);
        press(16'h1123);
        check("score_tick_err", 32'(err), 0);
        check("score_tick_phase", 32'(phase), 32'(SCORE));
        check("score_tick_req", 32'(score_req), 1);
        ack(3'd4, 3'd0);
        check("win_phase", 32'(phase), 32'(WIN));
        check("win_wins_j2", 32'(wins_j2), 1);
        check("win_wins_j1", 32'(wins_j1), 0);
        check("win_player", 32'(player), 1);
        check("win_last_bulls", 32'(last_bulls), 4);
        press(16'hFFFF);
        check("new_round_phase", 32'(phase), 32'(SETUP_J1));
        check("new_round_attempts", 32'(attempts), 0);
        check("new_round_player", 32'(player), 0);
        check("new_round_wins_j2", 32'(wins_j2), 1);
        check("new_round_last_bulls", 32'(last_bulls), 0);

        // Entry rejection in SETUP_J1
        press(16'h1123);
        check("rep_err", 32'(err), 1);
        check("rep_phase", 32'(phase), 32'(SETUP_J1));
        press(16'h1A23);
        check("hex_err", 32'(err), 1);
        check("hex_phase", 32'(phase), 32'(SETUP_J1));
        press(16'h1023);
        check("ok_err", 32'(err), 0);
        check("ok_phase", 32'(phase), 32'(SETUP_J2));
        press(16'h5678);
        check("round2_phase", 32'(phase), 32'(GUESS));

        // Attempt counter saturation
        for (int i = 1; i <= 17; i++) begin
            press(16'h5670);
            if (i >= 15) check("sat_j1_attempts", 32'(attempts), (i > 15) ? 15 : i);
            if (i < 17) begin
                ack(3'd1, 3'd2);
                if (i == 1) check("sat_last_cows", 32'(last_cows), 2);
                press(16'h0123);
                if (i == 16) check("sat_j2_attempts", 32'(attempts), 15);
                ack(3'd0, 3'd1);
            end
        end
        check("sat_req", 32'(score_req), 1);

        // Reset in the middle of scoring
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", 32'(score_req), 0);
        check("mid_rst_phase", 32'(phase), 32'(SETUP_J1));
        check("mid_rst_attempts", 32'(attempts), 0);
        @(negedge clock);
        reset = 1'b0;
        ack(3'd4, 3'd3);
        check("post_rst_phase", 32'(phase), 32'(SETUP_J1));
        check("post_rst_req", 32'(score_req), 0);
        check("post_rst_last_bulls", 32'(last_bulls), 0);
        check("post_rst_wins_j2", 32'(wins_j2), 0);

        // Button held across reset release
        @(negedge clock);
        guess   = 16'h1234;
        confirm = 1'b1;
        reset   = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        check("held_phase", 32'(phase), 32'(SETUP_J1));
        check("held_err", 32'(err), 0);
        confirm = 1'b0;
        repeat (3) @(negedge clock);
        press(16'h1234);
        check("after_held_phase", 32'(phase), 32'(SETUP_J2));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/turn_sequencer.md
TURN_SEQUENCER -- requirements
Module: turn_sequencer

Interface
REQ-001 Parameter CNT_W, default 4: width of the attempt and win counters, which saturate at 2^CNT_W-1.
REQ-002 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-003 Port reset, input, 1: asynchronous, active-high reset.
REQ-004 Port guess, input, 16: four BCD digits; [15:12] is the leftmost digit.
REQ-005 Port confirm, input, 1: raw, unsynchronised player push-button.
REQ-006 Port score_req, output, 1: compare request to the scoring datapath.
REQ-007 Port score_guess, output, 16: latched guess under comparison; stable while score_req=1.
REQ-008 Port score_secret, output, 16: opponent's secret; stable while score_req=1.
REQ-009 Port score_ack, input, 1: scoring datapath result valid.
REQ-010 Port bulls, input, 3: bulls count from the datapath (0-4).
REQ-011 Port cows, input, 3: cows count from the datapath (0-4).
REQ-012 Port phase, output, 3: current state encoding, from the shared package.
REQ-013 Port player, output, 1: active player; 0=J1, 1=J2.
REQ-014 Port attempts, output, CNT_W: accepted guesses of the active player this round.
REQ-015 Port wins_j1, output, CNT_W: rounds won by J1.
REQ-016 Port wins_j2, output, CNT_W: rounds won by J2.
REQ-017 Port last_bulls, output, 3: bulls from the most recent score.
REQ-018 Port last_cows, output, 3: cows from the most recent score.
REQ-019 Port err, output, 1: last confirmed entry was rejected.

Function
REQ-020 Confirm: 2-flop synchroniser plus rising-edge detect gives a 1-cycle tick; tick occurs 3 clocks after confirm rises; holding confirm high gives one tick only.
REQ-021 Valid entry: every nibble <=9 and all four nibbles pairwise distinct.
REQ-022 Tick with invalid entry: err=1 until the next tick, no state, secret or counter change.
REQ-023 Tick with valid entry: err=0.
REQ-024 States: SETUP_J1, SETUP_J2, GUESS, SCORE, WIN.
REQ-025 SETUP_J1, valid tick: store J1 secret -> SETUP_J2.
REQ-026 SETUP_J2, valid tick: store J2 secret, player=0 -> GUESS.
REQ-027 GUESS, valid tick: latch guess into score_guess, set score_secret to the opponent's secret, increment the active player's attempts (saturating), score_req=1 on the next cycle -> SCORE.
REQ-028 SCORE: score_req stays 1 until score_ack is sampled high; score_req drops in the same edge that consumes ack.
REQ-029 score_ack seen while score_req=0 is ignored; ticks during SCORE are ignored and do not set err.
REQ-030 On ack with bulls==4: latch last_bulls/last_cows, increment the winner's wins (saturating) -> WIN; player unchanged.
REQ-031 On ack with bulls!=4: latch last_bulls/last_cows, toggle player -> GUESS.
REQ-032 WIN, any tick (validity not checked): clear both attempt counters, secrets, last_bulls and last_cows, player=0 -> SETUP_J1; wins retained.
REQ-033 phase, player and attempts are registered outputs; attempts always muxes the counter of the current player.

Reset
REQ-034 On reset, immediately: state=SETUP_J1, score_req=0, err=0, player=0, every counter, secret, score_guess, score_secret, last_bulls and last_cows = 0, synchroniser flops = 0.
REQ-035 Reset during SCORE drops score_req asynchronously; a later ack is ignored.
REQ-036 No tick is generated by a confirm held high across reset release; a rising edge is required.

Structure
REQ-037 Package bc_pkg holds: the phase enum (SETUP_J1=0, SETUP_J2=1, GUESS=2, SCORE=3, WIN=4), the DIGITS=4 constant and the BULLS_WIN=4 constant.
REQ-038 Confirm synchroniser and edge detector are a sub-module, btn_edge (clock, reset, in, tick).
REQ-039 Scoring arithmetic stays outside this block.

Verification
REQ-040 Setup: reset; enter 0x1234 then 0x5678 -> phase=GUESS, player=0, attempts=0, err=0.
REQ-041 Invalid entry: in SETUP_J1 enter 0x1123 -> err=1, phase unchanged; then enter 0x1A23 -> err=1 remains; then enter 0x1023 -> err=0, phase=SETUP_J2.
REQ-042 Handshake: J1 guess 0x5670 -> score_req=1, score_secret=0x5678; ack delayed 5 cycles with bulls=3, cows=0 -> req held all 5 cycles, last_bulls=3, player=1, attempts=0 (J2).
REQ-043 Win: J2 guess 0x1234, ack with bulls=4 -> phase=WIN, wins_j2=1; a tick then -> SETUP_J1, attempts=0, wins_j2=1.
REQ-044 Saturation: 17 non-winning J1 guesses -> J1 attempts stops at 15.
REQ-045 Reset mid-SCORE: reset asserted while score_req=1 -> score_req=0 with no clock edge; a stale ack after release -> no change, phase=SETUP_J1.
